// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches one word per commit over a valid/ready
// read channel, holds it for the core, and latches a sticky error on bad response/commit/timeout.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_arvalid,
  output logic [31:0] mem_araddr,
  input  logic        mem_arready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  output logic        mem_rready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        inst_ready,
  input  logic        commit_valid,
  input  logic [31:0] commit_dnpc,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    EXEC  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  tmo_cnt;
  logic        load_inst;
  logic        load_pc;
  logic        tmo_inc;
  logic        tmo_hit;
  logic        dnpc_misaligned;

  assign tmo_hit         = (tmo_cnt == TMO_LAST);
  assign dnpc_misaligned = |commit_dnpc[1:0];

  always_comb begin
    state_nxt = state;
    load_inst = 1'b0;
    load_pc   = 1'b0;
    tmo_inc   = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        tmo_inc = 1'b1;
        if (tmo_hit) begin
          state_nxt = ERR;
        end else if (mem_arready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        tmo_inc = 1'b1;
        if (mem_rvalid) begin
          if (mem_rresp != 2'b00) begin
            state_nxt = ERR;
          end else begin
            load_inst = 1'b1;
            state_nxt = VALID;
          end
        end else if (tmo_hit) begin
          state_nxt = ERR;
        end
      end
      VALID: begin
        // a commit without the core taking the instruction is deliberately dropped
        if (inst_ready) begin
          if (commit_valid) begin
            load_pc   = 1'b1;
            state_nxt = dnpc_misaligned ? ERR : REQ;
          end else begin
            state_nxt = EXEC;
          end
        end
      end
      EXEC: begin
        if (commit_valid) begin
          load_pc   = 1'b1;
          state_nxt = dnpc_misaligned ? ERR : REQ;
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      inst      <= '0;
      fetch_cnt <= '0;
      tmo_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load_pc) begin
        pc <= commit_dnpc;
      end
      if (load_inst) begin
        inst      <= mem_rdata;
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (state_nxt == REQ && state != REQ) begin
        tmo_cnt <= '0;
      end else if (tmo_inc) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end

  // every output is a pure decode of registered state
  assign mem_arvalid = (state == REQ);
  assign mem_rready  = (state == WAIT);
  assign inst_valid  = (state == VALID);
  assign fetch_err   = (state == ERR);
  assign mem_araddr  = pc;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: behavioural memory plus scripted core; expected {pc, inst} pushed at commit time.
`timescale 1ns/1ps
module tb_ifu;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_ready;
  logic        commit_valid;
  logic [31:0] commit_dnpc;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  always #5 clk = ~clk;

  ifu #(.RESET_PC(RESET_PC), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rready(mem_rready),
    .inst_valid(inst_valid), .inst(inst), .pc(pc), .inst_ready(inst_ready),
    .commit_valid(commit_valid), .commit_dnpc(commit_dnpc),
    .fetch_err(fetch_err), .fetch_cnt(fetch_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;
  logic [31:0] exp_pc;
  int          exp_cnt;
  int          ar_lat = 0;
  int          r_lat = 0;
  int          ar_cnt = 0;
  int          r_cnt = 0;
  logic [1:0]  rresp_cfg = 2'b00;
  logic [31:0] ar_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h0000_0413;
    return a ^ 32'h1234_5003;
  endfunction

  // memory responds to the outputs of the current cycle; drives take effect at the next edge
  task automatic mem_model();
    if (mem_arvalid) begin
      if (ar_cnt >= ar_lat) begin
        mem_arready = 1'b1; ar_addr = mem_araddr; ar_cnt = 0;
      end else begin
        mem_arready = 1'b0; ar_cnt++;
      end
    end else begin
      mem_arready = 1'b0; ar_cnt = 0;
    end
    if (mem_rready) begin
      if (r_cnt >= r_lat) begin
        mem_rvalid = 1'b1; mem_rdata = mem_word(ar_addr); mem_rresp = rresp_cfg; r_cnt = 0;
      end else begin
        mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_BEEF; r_cnt++;
      end
    end else begin
      mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_BEEF; mem_rresp = 2'b00; r_cnt = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_model();
  endtask

  task automatic commit(input logic [31:0] d);
    inst_ready = 1'b1; commit_valid = 1'b1; commit_dnpc = d;
    if (d[1:0] == 2'b00) exp_q.push_back({d, mem_word(d)});
  endtask

  task automatic release_core();
    inst_ready = 1'b0; commit_valid = 1'b0;
  endtask

  task automatic wait_inst_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (inst_valid) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic boot(output bit ok);
    tick();
    rst = 1'b0;
    tick(); tick();
    exp_q.delete();
    exp_q.push_back({RESET_PC, mem_word(RESET_PC)});
    exp_cnt = 0; exp_pc = RESET_PC;
    ar_lat = 0; r_lat = 0; rresp_cfg = 2'b00;
    release_core();
    rst = 1'b1;
    wait_inst_valid(20, ok);
    if (ok) begin e = exp_q.pop_front(); exp_cnt = 1; end
  endtask

  task automatic test_reset();
    rst = 1'b0; release_core(); commit_dnpc = '0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = 2'b00;
    repeat (3) tick();
    checks++;
    if ({mem_arvalid, mem_rready, inst_valid, fetch_err} !== 4'b0000)
      begin errors++; $display("FAIL reset_hs got %b exp 0000", {mem_arvalid, mem_rready, inst_valid, fetch_err}); end
    checks++;
    if (pc !== RESET_PC || inst !== 32'h0 || fetch_cnt !== 32'h0)
      begin errors++; $display("FAIL reset_regs got pc=%h inst=%h cnt=%0d exp pc=%h 0 0", pc, inst, fetch_cnt, RESET_PC); end
    exp_q.delete();
    exp_q.push_back({RESET_PC, mem_word(RESET_PC)});
    exp_pc = RESET_PC; exp_cnt = 0;
    rst = 1'b1;
    tick();
    checks++;
    if (mem_arvalid !== 1'b1 || mem_araddr !== RESET_PC)
      begin errors++; $display("FAIL first_req got arvalid=%b addr=%h exp 1 %h", mem_arvalid, mem_araddr, RESET_PC); end
    tick();
    checks++;
    if (mem_rready !== 1'b1 || inst_valid !== 1'b0)
      begin errors++; $display("FAIL first_wait got rready=%b ivalid=%b exp 1 0", mem_rready, inst_valid); end
    tick();
    checks++;
    if (inst_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b exp 1", inst_valid); end
    e = exp_q.pop_front(); exp_cnt++;
    checks++;
    if (inst !== e[31:0] || pc !== e[63:32])
      begin errors++; $display("FAIL first_inst got pc=%h inst=%h exp pc=%h inst=%h", pc, inst, e[63:32], e[31:0]); end
    checks++;
    if (fetch_cnt !== 32'd1) begin errors++; $display("FAIL first_cnt got %0d exp 1", fetch_cnt); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 9; i++) begin
      exp_pc = exp_pc + 32'd4;
      commit(exp_pc);
      tick();
      release_core();
      checks++;
      if (mem_arvalid !== 1'b1 || mem_araddr !== exp_pc)
        begin errors++; $display("FAIL b2b_addr[%0d] got arvalid=%b addr=%h exp 1 %h", i, mem_arvalid, mem_araddr, exp_pc); end
      tick(); tick();
      checks++;
      if (inst_valid !== 1'b1) begin errors++; $display("FAIL b2b_rate[%0d] got ivalid=%b exp 1", i, inst_valid); end
      e = exp_q.pop_front(); exp_cnt++;
      checks++;
      if (inst !== e[31:0] || pc !== e[63:32])
        begin errors++; $display("FAIL b2b_inst[%0d] got pc=%h inst=%h exp pc=%h inst=%h", i, pc, inst, e[63:32], e[31:0]); end
    end
    checks++;
    if (fetch_cnt !== 32'd10) begin errors++; $display("FAIL b2b_cnt got %0d exp 10", fetch_cnt); end
  endtask

  task automatic test_stall();
    int  ar_n;
    int  r_n;
    bit  bad;
    bit  got;
    ar_lat = 5; r_lat = 3;
    exp_pc = exp_pc + 32'd4;
    commit(exp_pc);
    tick();
    release_core();
    ar_n = 0; r_n = 0; bad = 1'b0; got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (mem_arvalid) begin ar_n++; if (mem_araddr !== exp_pc) bad = 1'b1; end
      if (mem_rready) r_n++;
      if (mem_rvalid) begin got = 1'b1; break; end
      tick();
    end
    tick();
    checks++;
    if (!got || inst_valid !== 1'b1 || fetch_err !== 1'b0)
      begin errors++; $display("FAIL stall_valid got rv=%b ivalid=%b err=%b exp 1 1 0", got, inst_valid, fetch_err); end
    checks++;
    if (ar_n != 6 || r_n != 4 || bad)
      begin errors++; $display("FAIL stall_hs got ar=%0d r=%0d addr_moved=%b exp 6 4 0", ar_n, r_n, bad); end
    e = exp_q.pop_front(); exp_cnt++;
    checks++;
    if (inst !== e[31:0] || pc !== e[63:32])
      begin errors++; $display("FAIL stall_inst got pc=%h inst=%h exp pc=%h inst=%h", pc, inst, e[63:32], e[31:0]); end
    ar_lat = 0; r_lat = 0;
  endtask

  task automatic test_exec();
    bit ok;
    bit bad;
    commit_valid = 1'b1; inst_ready = 1'b0; commit_dnpc = 32'h8000_0200;
    tick();
    release_core();
    checks++;
    if (inst_valid !== 1'b1 || pc !== exp_pc || mem_arvalid !== 1'b0)
      begin errors++; $display("FAIL lone_commit got ivalid=%b pc=%h arvalid=%b exp 1 %h 0", inst_valid, pc, mem_arvalid, exp_pc); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || mem_arvalid !== 1'b0)
      begin errors++; $display("FAIL exec_enter got ivalid=%b arvalid=%b exp 0 0", inst_valid, mem_arvalid); end
    bad = 1'b0;
    repeat (3) begin tick(); if (inst_valid || mem_arvalid || fetch_err) bad = 1'b1; end
    checks++;
    if (bad) begin errors++; $display("FAIL exec_hold got activity=1 exp 0"); end
    exp_pc = 32'h8000_0100;
    commit(exp_pc);
    tick();
    release_core();
    checks++;
    if (mem_arvalid !== 1'b1 || mem_araddr !== exp_pc)
      begin errors++; $display("FAIL exec_restart got arvalid=%b addr=%h exp 1 %h", mem_arvalid, mem_araddr, exp_pc); end
    wait_inst_valid(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL exec_fetch got timeout exp inst_valid"); end
    e = exp_q.pop_front(); exp_cnt++;
    checks++;
    if (inst !== e[31:0] || pc !== e[63:32])
      begin errors++; $display("FAIL exec_inst got pc=%h inst=%h exp pc=%h inst=%h", pc, inst, e[63:32], e[31:0]); end
  endtask

  task automatic test_err_rresp();
    bit ok;
    bit bad;
    rresp_cfg = 2'b10;
    exp_pc = exp_pc + 32'd4;
    commit(exp_pc);
    tick();
    release_core();
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin if (fetch_err) begin ok = 1'b1; break; end tick(); end
    checks++;
    if (!ok) begin errors++; $display("FAIL rresp_err got fetch_err=0 exp 1"); end
    inst_ready = 1'b1; commit_valid = 1'b1; commit_dnpc = 32'h8000_0000;
    bad = 1'b0;
    repeat (6) begin tick(); if ({mem_arvalid, mem_rready, inst_valid} !== 3'b000 || fetch_err !== 1'b1) bad = 1'b1; end
    release_core();
    checks++;
    if (bad || fetch_cnt !== exp_cnt)
      begin errors++; $display("FAIL rresp_hold got bad=%b cnt=%0d exp 0 %0d", bad, fetch_cnt, exp_cnt); end
    rresp_cfg = 2'b00;
  endtask

  task automatic test_err_align();
    bit ok;
    bit bad;
    boot(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL align_boot got timeout exp inst_valid"); end
    commit(32'h8000_0102);
    tick();
    release_core();
    checks++;
    if (fetch_err !== 1'b1 || pc !== 32'h8000_0102 || mem_arvalid !== 1'b0)
      begin errors++; $display("FAIL align_err got err=%b pc=%h arvalid=%b exp 1 80000102 0", fetch_err, pc, mem_arvalid); end
    commit_valid = 1'b1; inst_ready = 1'b1; commit_dnpc = 32'h8000_0008;
    bad = 1'b0;
    repeat (6) begin tick(); if ({mem_arvalid, mem_rready, inst_valid} !== 3'b000 || fetch_err !== 1'b1) bad = 1'b1; end
    release_core();
    checks++;
    if (bad || pc !== 32'h8000_0102)
      begin errors++; $display("FAIL align_hold got bad=%b pc=%h exp 0 80000102", bad, pc); end
  endtask

  task automatic test_err_timeout();
    bit ok;
    bit bad;
    int n;
    boot(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tmo_boot got timeout exp inst_valid"); end
    ar_lat = 100000;
    exp_pc = RESET_PC + 32'd4;
    commit(exp_pc);
    tick();
    release_core();
    n = 0;
    for (int c = 0; c < 400; c++) begin
      if (fetch_err) break;
      if (mem_arvalid) n++;
      tick();
    end
    checks++;
    if (fetch_err !== 1'b1 || n != 255)
      begin errors++; $display("FAIL tmo_err got err=%b req_cycles=%0d exp 1 255", fetch_err, n); end
    bad = 1'b0;
    repeat (6) begin tick(); if ({mem_arvalid, mem_rready, inst_valid} !== 3'b000 || fetch_err !== 1'b1) bad = 1'b1; end
    checks++;
    if (bad) begin errors++; $display("FAIL tmo_hold got handshake or err drop exp none"); end
    ar_lat = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    boot(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_boot got timeout exp inst_valid"); end
    r_lat = 5;
    commit(RESET_PC + 32'd4);
    tick();
    release_core();
    tick();
    checks++;
    if (mem_rready !== 1'b1) begin errors++; $display("FAIL mid_wait got rready=%b exp 1", mem_rready); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mem_arvalid, mem_rready, inst_valid, fetch_err} !== 4'b0000 || pc !== RESET_PC ||
        inst !== 32'h0 || fetch_cnt !== 32'h0)
      begin errors++; $display("FAIL mid_async got hs=%b pc=%h inst=%h cnt=%0d exp 0000 %h 0 0",
        {mem_arvalid, mem_rready, inst_valid, fetch_err}, pc, inst, fetch_cnt, RESET_PC); end
    tick();
    exp_q.delete();
    exp_q.push_back({RESET_PC, mem_word(RESET_PC)});
    r_lat = 0; exp_cnt = 0;
    rst = 1'b1;
    checks++;
    if (fetch_cnt !== 32'h0) begin errors++; $display("FAIL mid_cnt0 got %0d exp 0", fetch_cnt); end
    tick();
    checks++;
    if (mem_arvalid !== 1'b1 || mem_araddr !== RESET_PC)
      begin errors++; $display("FAIL mid_restart got arvalid=%b addr=%h exp 1 %h", mem_arvalid, mem_araddr, RESET_PC); end
    wait_inst_valid(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_fetch got timeout exp inst_valid"); end
    e = exp_q.pop_front();
    checks++;
    if (inst !== e[31:0] || pc !== e[63:32] || fetch_cnt !== 32'd1)
      begin errors++; $display("FAIL mid_inst got pc=%h inst=%h cnt=%0d exp pc=%h inst=%h cnt=1",
        pc, inst, fetch_cnt, e[63:32], e[31:0]); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_exec();
    test_err_rresp();
    test_err_align();
    test_err_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
